// File: rtl/rtc_pkg.sv
// Shared constants for the RTC APB register block: register word indices,
// CTRL field positions, interrupt source indices and core data widths.
package rtc_pkg;

  localparam int CLOCK_W    = 22;
  localparam int TIMER_W    = 17;
  localparam int DATE_W     = 32;
  localparam int INIT_CNT_W = 10;
  localparam int N_IRQ      = 2;

  // Word index decoded from paddr[4:2]; the byte offset is index * 4.
  typedef enum logic [2:0] {
    RTC_CTRL      = 3'd0,
    RTC_CLOCK     = 3'd1,
    RTC_ALARM     = 3'd2,
    RTC_TIMER     = 3'd3,
    RTC_DATE      = 3'd4,
    RTC_IRQ_FLAGS = 3'd5,
    RTC_IRQ_MASK  = 3'd6,
    RTC_STATUS    = 3'd7
  } reg_idx_e;

  localparam int CTRL_TIMER_EN     = 0;
  localparam int CTRL_TIMER_RETRIG = 1;
  localparam int CTRL_ALARM_EN     = 2;
  localparam int CTRL_INIT_LSB     = 16;

  localparam int IRQ_EVENT   = 0;
  localparam int IRQ_NEW_DAY = 1;

endpackage

// File: rtl/rtc_irq_ctrl.sv
// Sticky interrupt flags with write-1-to-clear, a mask register and a
// registered level interrupt. A set arriving with a clear of the same bit wins.
module rtc_irq_ctrl
  import rtc_pkg::*;
#(
  parameter int N_SRC = N_IRQ
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] set_i,
  input  logic [N_SRC-1:0] clr_i,
  input  logic             mask_we_i,
  input  logic [N_SRC-1:0] mask_wdata_i,
  output logic [N_SRC-1:0] flags_o,
  output logic [N_SRC-1:0] mask_o,
  output logic             irq_o
);

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; irq_o deliberately sees the old flags and mask.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_o <= '0;
      mask_o  <= '0;
      irq_o   <= 1'b0;
    end else begin
      flags_o <= (flags_o & ~clr_i) | set_i;
      if (mask_we_i) mask_o <= mask_wdata_i;
      irq_o <= |(flags_o & mask_o);
    end
  end

endmodule

// File: rtl/rtc_apb_regs.sv
// APB3 register front-end for the RTC core: held load values with one-cycle
// update strobes, live read-back, and maskable sticky interrupt flags.
module rtc_apb_regs
  import rtc_pkg::*;
#(
  parameter int                    APB_ADDR_WIDTH   = 12,
  parameter logic [INIT_CNT_W-1:0] INIT_SEC_CNT_RST = 10'h3FF,
  parameter logic [7:0]            VERSION          = 8'h01
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      rtc_clock_update_o,
  output logic [CLOCK_W-1:0]        rtc_clock_o,
  input  logic [CLOCK_W-1:0]        rtc_clock_i,
  output logic [INIT_CNT_W-1:0]     rtc_init_sec_cnt_o,
  output logic                      rtc_timer_update_o,
  output logic                      rtc_timer_enable_o,
  output logic                      rtc_timer_retrig_o,
  output logic [TIMER_W-1:0]        rtc_timer_target_o,
  input  logic [TIMER_W-1:0]        rtc_timer_value_i,
  output logic                      rtc_alarm_update_o,
  output logic                      rtc_alarm_enable_o,
  output logic [CLOCK_W-1:0]        rtc_alarm_clock_o,
  input  logic [CLOCK_W-1:0]        rtc_alarm_clock_i,
  output logic                      rtc_date_update_o,
  output logic [DATE_W-1:0]         rtc_date_o,
  input  logic [DATE_W-1:0]         rtc_date_i,
  input  logic                      rtc_event_i,
  input  logic                      rtc_update_day_i,
  output logic                      irq_o
);

  logic           access, addr_ok, wr_en, rd_en;
  logic           addr_lsb_unused;
  reg_idx_e       idx;
  logic [N_IRQ-1:0] irq_flags, irq_mask, irq_clr;

  // Upper address bits select nothing: any non-zero value is an error access.
  assign access    = psel_i & penable_i;
  assign addr_ok   = ~|paddr_i[APB_ADDR_WIDTH-1:5];
  assign wr_en     = access & pwrite_i & addr_ok;
  assign rd_en     = access & ~pwrite_i & addr_ok;
  assign pslverr_o = access & ~addr_ok;
  assign pready_o  = 1'b1;
  assign idx       = reg_idx_e'(paddr_i[4:2]);
  assign addr_lsb_unused = ^paddr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rtc_clock_update_o <= 1'b0;
      rtc_alarm_update_o <= 1'b0;
      rtc_timer_update_o <= 1'b0;
      rtc_date_update_o  <= 1'b0;
      rtc_clock_o        <= '0;
      rtc_alarm_clock_o  <= '0;
      rtc_timer_target_o <= '0;
      rtc_date_o         <= '0;
      rtc_timer_enable_o <= 1'b0;
      rtc_timer_retrig_o <= 1'b0;
      rtc_alarm_enable_o <= 1'b0;
      rtc_init_sec_cnt_o <= INIT_SEC_CNT_RST;
    end else begin
      rtc_clock_update_o <= 1'b0;
      rtc_alarm_update_o <= 1'b0;
      rtc_timer_update_o <= 1'b0;
      rtc_date_update_o  <= 1'b0;
      if (wr_en) begin
        case (idx)
          RTC_CTRL: begin
            rtc_timer_enable_o <= pwdata_i[CTRL_TIMER_EN];
            rtc_timer_retrig_o <= pwdata_i[CTRL_TIMER_RETRIG];
            rtc_alarm_enable_o <= pwdata_i[CTRL_ALARM_EN];
            rtc_init_sec_cnt_o <= pwdata_i[CTRL_INIT_LSB +: INIT_CNT_W];
          end
          RTC_CLOCK: begin
            rtc_clock_o        <= pwdata_i[CLOCK_W-1:0];
            rtc_clock_update_o <= 1'b1;
          end
          RTC_ALARM: begin
            rtc_alarm_clock_o  <= pwdata_i[CLOCK_W-1:0];
            rtc_alarm_update_o <= 1'b1;
          end
          RTC_TIMER: begin
            rtc_timer_target_o <= pwdata_i[TIMER_W-1:0];
            rtc_timer_update_o <= 1'b1;
          end
          RTC_DATE: begin
            rtc_date_o        <= pwdata_i[DATE_W-1:0];
            rtc_date_update_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign irq_clr = (wr_en && idx == RTC_IRQ_FLAGS) ? pwdata_i[N_IRQ-1:0] : '0;

  rtc_irq_ctrl #(.N_SRC(N_IRQ)) u_irq (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .set_i        ({rtc_update_day_i, rtc_event_i}),
    .clr_i        (irq_clr),
    .mask_we_i    (wr_en && idx == RTC_IRQ_MASK),
    .mask_wdata_i (pwdata_i[N_IRQ-1:0]),
    .flags_o      (irq_flags),
    .mask_o       (irq_mask),
    .irq_o        (irq_o)
  );

  // NOTE: prdata_o gets a default before the case so no path infers a latch.
  always_comb begin
    prdata_o = '0;
    if (rd_en) begin
      case (idx)
        RTC_CTRL: begin
          prdata_o[CTRL_TIMER_EN]                = rtc_timer_enable_o;
          prdata_o[CTRL_TIMER_RETRIG]            = rtc_timer_retrig_o;
          prdata_o[CTRL_ALARM_EN]                = rtc_alarm_enable_o;
          prdata_o[CTRL_INIT_LSB +: INIT_CNT_W]  = rtc_init_sec_cnt_o;
        end
        RTC_CLOCK:     prdata_o[CLOCK_W-1:0] = rtc_clock_i;
        RTC_ALARM:     prdata_o[CLOCK_W-1:0] = rtc_alarm_clock_i;
        RTC_TIMER:     prdata_o[TIMER_W-1:0] = rtc_timer_value_i;
        RTC_DATE:      prdata_o[DATE_W-1:0]  = rtc_date_i;
        RTC_IRQ_FLAGS: prdata_o[N_IRQ-1:0]   = irq_flags;
        RTC_IRQ_MASK:  prdata_o[N_IRQ-1:0]   = irq_mask;
        RTC_STATUS: begin
          prdata_o[7:0] = VERSION;
          prdata_o[8]   = irq_o;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_apb_regs.sv
// Directed bench for rtc_apb_regs: APB reads/writes, strobe timing, interrupt
// flags and mask, error accesses and reset cancelling a pending strobe.
module tb_rtc_apb_regs;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] paddr_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic        rtc_clock_update_o, rtc_timer_update_o, rtc_alarm_update_o, rtc_date_update_o;
  logic [21:0] rtc_clock_o, rtc_alarm_clock_o;
  logic [21:0] rtc_clock_i, rtc_alarm_clock_i;
  logic [9:0]  rtc_init_sec_cnt_o;
  logic        rtc_timer_enable_o, rtc_timer_retrig_o, rtc_alarm_enable_o;
  logic [16:0] rtc_timer_target_o, rtc_timer_value_i;
  logic [31:0] rtc_date_o, rtc_date_i;
  logic        rtc_event_i, rtc_update_day_i;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]  strb;
  logic [31:0] rd;
  logic        err;

  assign strb = {rtc_clock_update_o, rtc_alarm_update_o, rtc_timer_update_o, rtc_date_update_o};

  rtc_apb_regs dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .paddr_i            (paddr_i),
    .psel_i             (psel_i),
    .penable_i          (penable_i),
    .pwrite_i           (pwrite_i),
    .pwdata_i           (pwdata_i),
    .prdata_o           (prdata_o),
    .pready_o           (pready_o),
    .pslverr_o          (pslverr_o),
    .rtc_clock_update_o (rtc_clock_update_o),
    .rtc_clock_o        (rtc_clock_o),
    .rtc_clock_i        (rtc_clock_i),
    .rtc_init_sec_cnt_o (rtc_init_sec_cnt_o),
    .rtc_timer_update_o (rtc_timer_update_o),
    .rtc_timer_enable_o (rtc_timer_enable_o),
    .rtc_timer_retrig_o (rtc_timer_retrig_o),
    .rtc_timer_target_o (rtc_timer_target_o),
    .rtc_timer_value_i  (rtc_timer_value_i),
    .rtc_alarm_update_o (rtc_alarm_update_o),
    .rtc_alarm_enable_o (rtc_alarm_enable_o),
    .rtc_alarm_clock_o  (rtc_alarm_clock_o),
    .rtc_alarm_clock_i  (rtc_alarm_clock_i),
    .rtc_date_update_o  (rtc_date_update_o),
    .rtc_date_o         (rtc_date_o),
    .rtc_date_i         (rtc_date_i),
    .rtc_event_i        (rtc_event_i),
    .rtc_update_day_i   (rtc_update_day_i),
    .irq_o              (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Setup phase, access phase, then idle. Returns at the negedge of the cycle
  // after the access edge, i.e. inside the strobe cycle.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
    @(negedge clk_i);
    paddr_i = a; pwdata_i = d; pwrite_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1 e = pslverr_o;
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge clk_i);
    paddr_i = a; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1 d = prdata_o; e = pslverr_o;
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; paddr_i = '0; psel_i = 0; penable_i = 0; pwrite_i = 0; pwdata_i = '0;
    rtc_event_i = 0; rtc_update_day_i = 0;
    rtc_clock_i = 22'h2A_5A5A; rtc_alarm_clock_i = 22'h15_1234;
    rtc_timer_value_i = 17'h1_ABCD; rtc_date_i = 32'hCAFE_F00D;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Reset state
    check("rst_strb", 32'(strb), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_pready", 32'(pready_o), 32'h1);
    check("rst_init", 32'(rtc_init_sec_cnt_o), 32'h3FF);
    apb_read(12'h000, rd, err); check("rd_ctrl_rst", rd, 32'h03FF_0000);
    check("rd_ctrl_err", 32'(err), 32'h0);
    apb_read(12'h014, rd, err); check("rd_flags_rst", rd, 32'h0);
    apb_read(12'h018, rd, err); check("rd_mask_rst", rd, 32'h0);
    apb_read(12'h01C, rd, err); check("rd_status_rst", rd, 32'h0000_0001);
    apb_read(12'h006, rd, err); check("rd_clock_live", rd, 32'h002A_5A5A);
    apb_read(12'h008, rd, err); check("rd_alarm_live", rd, 32'h0015_1234);
    apb_read(12'h00C, rd, err); check("rd_timer_live", rd, 32'h0001_ABCD);
    apb_read(12'h010, rd, err); check("rd_date_live", rd, 32'hCAFE_F00D);

    // Data writes: strobe and data together for exactly one cycle
    apb_write(12'h004, 32'h0012_3456, err);
    check("clk_strb", 32'(strb), 32'h8); check("clk_data", 32'(rtc_clock_o), 32'h0012_3456);
    @(negedge clk_i); check("clk_strb_off", 32'(strb), 32'h0);
    apb_write(12'h008, 32'hFFFA_BCDE, err);
    check("alm_strb", 32'(strb), 32'h4); check("alm_data", 32'(rtc_alarm_clock_o), 32'h003A_BCDE);
    @(negedge clk_i); check("alm_strb_off", 32'(strb), 32'h0);
    apb_write(12'h00C, 32'h0001_0000, err);
    check("tmr_strb", 32'(strb), 32'h2); check("tmr_data", 32'(rtc_timer_target_o), 32'h0001_0000);
    @(negedge clk_i); check("tmr_strb_off", 32'(strb), 32'h0);
    apb_write(12'h010, 32'hDEAD_BEEF, err);
    check("date_strb", 32'(strb), 32'h1); check("date_data", rtc_date_o, 32'hDEAD_BEEF);
    @(negedge clk_i); check("date_strb_off", 32'(strb), 32'h0);

    // Back-to-back DATE writes held in access phase for two cycles
    @(negedge clk_i);
    paddr_i = 12'h010; pwrite_i = 1; psel_i = 1; penable_i = 0; pwdata_i = 32'h1111_1111;
    @(negedge clk_i); penable_i = 1;
    @(negedge clk_i); pwdata_i = 32'h2222_2222;
    check("b2b_strb1", 32'(strb), 32'h1); check("b2b_data1", rtc_date_o, 32'h1111_1111);
    @(negedge clk_i); psel_i = 0; penable_i = 0; pwrite_i = 0;
    check("b2b_strb2", 32'(strb), 32'h1); check("b2b_data2", rtc_date_o, 32'h2222_2222);
    @(negedge clk_i); check("b2b_strb_off", 32'(strb), 32'h0);

    // CTRL fields, no strobes
    apb_write(12'h000, 32'h0100_0007, err);
    check("ctrl_strb", 32'(strb), 32'h0);
    check("ctrl_fields", {28'h0, rtc_timer_enable_o, rtc_timer_retrig_o, rtc_alarm_enable_o, 1'b0}, 32'hE);
    check("ctrl_init", 32'(rtc_init_sec_cnt_o), 32'h100);
    apb_read(12'h000, rd, err); check("rd_ctrl", rd, 32'h0100_0007);

    // Interrupts
    apb_write(12'h018, 32'h0000_0001, err);
    @(negedge clk_i); rtc_event_i = 1; rtc_update_day_i = 1;
    @(negedge clk_i); rtc_event_i = 0; rtc_update_day_i = 0;
    check("irq_lag", 32'(irq_o), 32'h0);
    @(negedge clk_i); check("irq_set", 32'(irq_o), 32'h1);
    apb_read(12'h014, rd, err); check("rd_flags_11", rd, 32'h3);
    apb_read(12'h01C, rd, err); check("rd_status_irq", rd, 32'h0000_0101);
    apb_write(12'h014, 32'h0000_0001, err);
    @(negedge clk_i); check("irq_clr", 32'(irq_o), 32'h0);
    apb_read(12'h014, rd, err); check("rd_flags_10", rd, 32'h2);

    // W1C colliding with a new event: set wins
    @(negedge clk_i); rtc_event_i = 1;
    @(negedge clk_i); rtc_event_i = 0;
    @(negedge clk_i); check("irq_reset", 32'(irq_o), 32'h1);
    paddr_i = 12'h014; pwdata_i = 32'h1; pwrite_i = 1; psel_i = 1; penable_i = 0;
    @(negedge clk_i); penable_i = 1; rtc_event_i = 1;
    @(negedge clk_i); psel_i = 0; penable_i = 0; pwrite_i = 0; rtc_event_i = 0;
    @(negedge clk_i); check("irq_set_wins1", 32'(irq_o), 32'h1);
    @(negedge clk_i); check("irq_set_wins2", 32'(irq_o), 32'h1);
    apb_read(12'h014, rd, err); check("rd_flags_win", rd, 32'h3);

    // Masking the source drops irq one cycle later
    apb_write(12'h018, 32'h0000_0000, err);
    check("irq_mask_lag", 32'(irq_o), 32'h1);
    @(negedge clk_i); check("irq_masked", 32'(irq_o), 32'h0);

    // Unmapped address, STATUS write, setup-only phase
    apb_write(12'h040, 32'hFFFF_FFFF, err);
    check("slverr_wr", 32'(err), 32'h1); check("slverr_strb", 32'(strb), 32'h0);
    apb_read(12'h040, rd, err); check("slverr_rd", 32'(err), 32'h1); check("slverr_rd_data", rd, 32'h0);
    apb_read(12'h000, rd, err); check("slverr_ctrl_kept", rd, 32'h0100_0007);
    apb_read(12'h018, rd, err); check("slverr_mask_kept", rd, 32'h0);
    apb_write(12'h01C, 32'hFFFF_FFFF, err); check("status_wr_noerr", 32'(err), 32'h0);
    @(negedge clk_i);
    paddr_i = 12'h004; pwdata_i = 32'h0000_0001; pwrite_i = 1; psel_i = 1; penable_i = 0;
    @(negedge clk_i); psel_i = 0; pwrite_i = 0;
    check("setup_strb", 32'(strb), 32'h0); check("setup_data", 32'(rtc_clock_o), 32'h0012_3456);

    // Reset during the strobe cycle of a DATE write
    apb_write(12'h010, 32'h1234_5678, err);
    check("pre_rst_strb", 32'(strb), 32'h1);
    rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    check("post_rst_strb", 32'(strb), 32'h0); check("post_rst_date", rtc_date_o, 32'h0);
    check("post_rst_init", 32'(rtc_init_sec_cnt_o), 32'h3FF);
    @(negedge clk_i); check("post_rst_strb2", 32'(strb), 32'h0);

    // Reset during the access phase cancels the pending strobe
    paddr_i = 12'h004; pwdata_i = 32'h0000_00AA; pwrite_i = 1; psel_i = 1; penable_i = 0;
    @(negedge clk_i); penable_i = 1; rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; psel_i = 0; penable_i = 0; pwrite_i = 0;
    check("acc_rst_strb", 32'(strb), 32'h0); check("acc_rst_clock", 32'(rtc_clock_o), 32'h0);
    @(negedge clk_i); check("acc_rst_strb2", 32'(strb), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
